uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
Parametrised UART receiver for the pipeline system's serial input path.
- Generalises the fixed 8N1, 9600-baud receive path to configurable baud, data width, parity mode and stop bits.
- Adds a receive FIFO, per-character error flags, an overrun indication and false-start rejection.
- Sits between the board rxd pin and the CPU's memory-mapped UART peripheral registers.

Parameters:
- CLK_FREQ, 100000000: sysclk frequency in Hz.
- BAUD, 9600: line rate in bit/s.
- OVERSAMPLE, 16: sample ticks per bit. Even, >=8.
- DATA_BITS, 8: data bits per character, 5..9, LSB first.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: receive FIFO entries, >=2.

Ports:
- sysclk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- rxd  in  1  asynchronous serial input; idle high.
- rd_en  in  1  pop the FIFO head. Ignored when rd_valid=0.
- rd_valid  out  1  FIFO not empty.
- rd_data  out  DATA_BITS  FIFO head data (first-word-fall-through).
- rd_parity_err  out  1  parity error flag of the head entry.
- rd_frame_err  out  1  frame error flag of the head entry.
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries.
- overrun  out  1  one-cycle pulse when a character is dropped.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE; all counters clear; FIFO empties.
  - Both synchroniser flops reset to 1.
  - Outputs: rd_valid=0, rd_data=0, both error flags=0, fifo_full=0, overrun=0.
  - Reset mid-frame discards the partial character; no push occurs.
- Input path: rxd passes through a 2-flop synchroniser; call the result rxs.
- Tick generator:
  - DIV = round(CLK_FREQ / (BAUD*OVERSAMPLE)), at least 1.
  - Free-running counter produces a 1-cycle tick every DIV cycles.
  - Counter is restarted on the start-edge detection so sampling phase is aligned to the edge.
- Sample counter scnt counts ticks within a bit. The mid-bit sample is taken when scnt = OVERSAMPLE/2-1 for the start bit, and every OVERSAMPLE ticks after that.
- FSM states:
  - IDLE -> START on rxs falling edge (rxs=0 with previous value 1).
  - START: at mid-bit, rxs=1 -> IDLE (false start, nothing pushed); rxs=0 -> DATA.
  - DATA: shift in DATA_BITS samples, LSB first. Then go to PARITY if PARITY!=0, otherwise STOP.
  - PARITY: sample the bit. perr = (computed parity of data incl. sampled bit) mismatches the mode: odd requires an odd total count of ones, even requires an even count.
  - STOP: sample STOP_BITS bits. ferr=1 if any sampled stop bit is 0.
    - After the last stop sample, push {data, perr, ferr}.
    - If ferr=0, go to IDLE.
    - If ferr=1, go to BREAK.
  - BREAK: wait for rxs=1, then go to IDLE. This prevents a held-low line from producing repeated characters.
- Push timing: the push happens in the cycle after the final stop-bit mid-sample. Resync is possible within the same stop bit, so back-to-back frames are received with no idle gap.
- FIFO:
  - Circular buffer; pointers wrap from FIFO_DEPTH-1 to 0.
  - Count width is clog2(FIFO_DEPTH+1).
  - Push while full and no pop: the character is dropped, overrun=1 for one cycle, contents are unchanged.
  - Push and pop in the same cycle while full: both are accepted; count unchanged; no overrun.
  - Push and pop in the same cycle while empty: the push is accepted and rd_valid rises next cycle. No bypass path.
  - rd_en while empty has no effect.
- rd_data, rd_parity_err and rd_frame_err reflect the head entry and are 0 when empty.

Decomposition:
- Package uart_pkg holds:
  - parity mode constants PAR_NONE/PAR_ODD/PAR_EVEN;
  - the FSM state encoding IDLE/START/DATA/PARITY/STOP/BREAK;
  - a constant function computing DIV from CLK_FREQ, BAUD and OVERSAMPLE.
- One sub-module, uart_rx_fifo: a synchronous first-word-fall-through FIFO parametrised by width and depth. The width here is DATA_BITS+2, carrying data plus the two error flags.

Test Plan:
All scenarios use CLK_FREQ=1536000, BAUD=9600, OVERSAMPLE=16, giving DIV=10 and 160 cycles per bit.
1. 8N1, send 0xB9 -> rd_valid rises about 1524 cycles after the start edge (9.5 bit times plus the 2-cycle synchroniser); rd_data=0xB9; both error flags 0; rd_en pulse -> rd_valid=0.
2. Send 0x96, then 15 idle bit times, then 0x1E; then send 0xAA and 0x55 with no gap -> four entries, popped in the order 0x96, 0x1E, 0xAA, 0x55, all error-free.
3. PARITY=2, send 0x96 with parity bit 1 (correct value is 0) -> rd_data=0x96, rd_parity_err=1. Resend with parity bit 0 -> rd_parity_err=0.
4. Hold rxd low for 12 bit times, then high -> exactly one entry, rd_data=0x00, rd_frame_err=1. No second entry appears until rxd returns high and a new start bit arrives.
5. FIFO_DEPTH=4, send 0x01..0x05 without reading -> fifo_full=1 after 0x04; overrun pulses once at 0x05's push; pops return 0x01..0x04. Separately, assert rd_en in the same cycle as a push while full -> no overrun.
6. rxd low for 40 cycles (shorter than half a bit) -> no entry. Separately, assert reset low mid-DATA -> rd_valid=0 and FSM in IDLE; the next clean frame 0x3C is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver.
// Parity mode codes, receive FSM encoding and the tick divider calculation.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    // Rounded clock divide for one oversample tick, never below 1.
    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        int step;
        int div;
        step = baud * oversample;
        div  = (clk_freq + step / 2) / step;
        return (div < 1) ? 1 : div;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO; a write shows at the head one cycle later (no bypass).
// No backpressure: a write into a full FIFO without a pop is dropped and flagged on o_overrun.
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic             o_rd_valid,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_overrun
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_cnt;
    logic             r_ovr;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_cnt == '0);
    assign w_full  = (r_cnt == CW'(DEPTH));
    assign w_pop   = i_rd_en & ~w_empty;
    // A pop frees the slot in the same cycle, so a push while full still lands.
    assign w_push  = i_wr_en & (~w_full | w_pop);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            r_ovr  <= 1'b0;
        end else begin
            r_ovr <= i_wr_en & w_full & ~w_pop;
            if (w_push) r_wptr <= ptr_inc(r_wptr);
            if (w_pop)  r_rptr <= ptr_inc(r_rptr);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_wr_data;
    end

    assign o_rd_valid = ~w_empty;
    assign o_rd_data  = w_empty ? '0 : r_mem[r_rptr];
    assign o_full     = w_full;
    assign o_overrun  = r_ovr;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver feeding a FWFT receive FIFO with per-character error flags.
// Character pushed one cycle after the last stop mid-sample; no backpressure, full FIFO drops and pulses overrun.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 sysclk,
    input  logic                 reset,
    input  logic                 rxd,
    input  logic                 rd_en,
    output logic                 rd_valid,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_parity_err,
    output logic                 rd_frame_err,
    output logic                 fifo_full,
    output logic                 overrun
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int BW  = 4;
    localparam int EW  = DATA_BITS + 2;

    logic [1:0]           r_sync;
    logic                 r_rxs_d;
    rx_state_t            r_state;
    logic [TW-1:0]        r_tcnt;
    logic [SW-1:0]        r_scnt;
    logic [BW-1:0]        r_bcnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_push;

    rx_state_t            w_next;
    logic                 w_rxs;
    logic                 w_tick;
    logic                 w_fall;
    logic                 w_sample;
    logic                 w_last_data;
    logic                 w_last_stop;
    logic                 w_ferr_now;
    logic                 w_ones_odd;
    logic                 w_par_err;
    logic [EW-1:0]        w_wr_data;
    logic [EW-1:0]        w_head;

    assign w_rxs       = r_sync[1];
    assign w_tick      = (r_tcnt == TW'(DIV - 1));
    assign w_last_data = (r_bcnt == BW'(DATA_BITS - 1));
    assign w_last_stop = (r_bcnt == BW'(STOP_BITS - 1));
    assign w_ferr_now  = r_ferr | ~w_rxs;
    assign w_ones_odd  = (^r_shift) ^ w_rxs;
    assign w_par_err   = (PARITY == PAR_ODD) ? ~w_ones_odd : w_ones_odd;

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_sync  <= 2'b11;
            r_rxs_d <= 1'b1;
        end else begin
            r_sync  <= {r_sync[0], rxd};
            r_rxs_d <= w_rxs;
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_fall) w_next = ST_START;
            ST_START:  if (w_sample) w_next = w_rxs ? ST_IDLE : ST_DATA;
            ST_DATA:   if (w_sample && w_last_data)
                           w_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            ST_PARITY: if (w_sample) w_next = ST_STOP;
            ST_STOP:   if (w_sample && w_last_stop)
                           w_next = w_ferr_now ? ST_BREAK : ST_IDLE;
            ST_BREAK:  if (w_rxs) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Start bit is checked at half a bit; every later sample is a full bit on.
    always_comb begin
        w_fall   = 1'b0;
        w_sample = 1'b0;
        case (r_state)
            ST_IDLE:  w_fall   = ~w_rxs & r_rxs_d;
            ST_START: w_sample = w_tick && (r_scnt == SW'(OVERSAMPLE / 2 - 1));
            ST_DATA, ST_PARITY, ST_STOP:
                      w_sample = w_tick && (r_scnt == SW'(OVERSAMPLE - 1));
            default:  ;
        endcase
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_tcnt  <= '0;
            r_scnt  <= '0;
            r_bcnt  <= '0;
            r_shift <= '0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_push  <= 1'b0;
        end else begin
            r_push <= 1'b0;

            if (w_fall || w_tick) r_tcnt <= '0;
            else                  r_tcnt <= r_tcnt + TW'(1);

            if (r_state == ST_IDLE || r_state == ST_BREAK) r_scnt <= '0;
            else if (w_tick) r_scnt <= w_sample ? '0 : r_scnt + SW'(1);

            if (w_fall) begin
                r_bcnt <= '0;
                r_perr <= 1'b0;
                r_ferr <= 1'b0;
            end

            if (w_sample) begin
                case (r_state)
                    ST_DATA: begin
                        r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
                        r_bcnt  <= w_last_data ? '0 : r_bcnt + BW'(1);
                    end
                    ST_PARITY: r_perr <= w_par_err;
                    ST_STOP: begin
                        r_ferr <= w_ferr_now;
                        r_bcnt <= w_last_stop ? '0 : r_bcnt + BW'(1);
                        r_push <= w_last_stop;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign w_wr_data = {r_shift, r_perr, r_ferr};

    uart_rx_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (sysclk),
        .i_rst_n    (reset),
        .i_wr_en    (r_push),
        .i_wr_data  (w_wr_data),
        .i_rd_en    (rd_en),
        .o_rd_valid (rd_valid),
        .o_rd_data  (w_head),
        .o_full     (fifo_full),
        .o_overrun  (overrun)
    );

    assign rd_data       = w_head[EW-1:2];
    assign rd_parity_err = w_head[1];
    assign rd_frame_err  = w_head[0];

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: an 8N1 instance (a) and an even-parity instance (b).
// Serial stimulus is driven on the falling clock edge; outputs are sampled there as well.
module tb_uart_rx_param;

    localparam int BIT = 160;

    typedef struct packed {
        logic [7:0] d;
        logic       p;
        logic       f;
    } ent_t;

    typedef struct packed {
        logic [7:0] d;
        logic       bad_par;
        logic       bad_stop;
        logic [7:0] exp_d;
        logic       exp_p;
        logic       exp_f;
    } vec_t;

    logic       sysclk = 1'b0;
    logic       reset  = 1'b0;
    logic       rxd_a  = 1'b1;
    logic       rxd_b  = 1'b1;
    logic       rd_en_a = 1'b0;
    logic       rd_en_b = 1'b0;
    logic       vld_a, vld_b, pe_a, pe_b, fe_a, fe_b, full_a, full_b, ovr_a, ovr_b;
    logic [7:0] dat_a, dat_b;

    ent_t q_a[$];
    ent_t q_b[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   ovr_cnt = 0;

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) if (ovr_a) ovr_cnt <= ovr_cnt + 1;

    uart_rx_param #(
        .CLK_FREQ(1536000), .BAUD(9600), .OVERSAMPLE(16), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) u_dut_a (
        .sysclk(sysclk), .reset(reset), .rxd(rxd_a), .rd_en(rd_en_a),
        .rd_valid(vld_a), .rd_data(dat_a), .rd_parity_err(pe_a),
        .rd_frame_err(fe_a), .fifo_full(full_a), .overrun(ovr_a)
    );

    uart_rx_param #(
        .CLK_FREQ(1536000), .BAUD(9600), .OVERSAMPLE(16), .DATA_BITS(8),
        .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) u_dut_b (
        .sysclk(sysclk), .reset(reset), .rxd(rxd_b), .rd_en(rd_en_b),
        .rd_valid(vld_b), .rd_data(dat_b), .rd_parity_err(pe_b),
        .rd_frame_err(fe_b), .fifo_full(full_b), .overrun(ovr_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit b, input logic v, input int ncyc);
        if (b) rxd_b = v;
        else   rxd_a = v;
        repeat (ncyc) @(negedge sysclk);
    endtask

    task automatic send_char(input bit b, input logic [7:0] d, input bit has_par,
                             input logic pbit, input logic stopv);
        drive(b, 1'b0, BIT);
        for (int i = 0; i < 8; i++) drive(b, d[i], BIT);
        if (has_par) drive(b, pbit, BIT);
        drive(b, stopv, BIT);
        if (b) rxd_b = 1'b1;
        else   rxd_a = 1'b1;
    endtask

    task automatic wait_valid(input bit b, input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ((b ? vld_b : vld_a) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge sysclk);
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: rd_valid stayed 0, expected 1", name);
        end
    endtask

    // Compare the FIFO head against the scoreboard front, then pop both.
    task automatic pop_chk(input bit b, input string name);
        bit   ok;
        ent_t e;
        wait_valid(b, name, ok);
        if ((b ? q_b.size() : q_a.size()) == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: unexpected entry, scoreboard empty", name);
        end else begin
            e = b ? q_b.pop_front() : q_a.pop_front();
            if (ok) begin
                chk({name, ".data"}, b ? dat_b : dat_a, e.d);
                chk({name, ".perr"}, b ? pe_b : pe_a, e.p);
                chk({name, ".ferr"}, b ? fe_b : fe_a, e.f);
            end
        end
        if (ok) begin
            if (b) rd_en_b = 1'b1;
            else   rd_en_a = 1'b1;
            @(negedge sysclk);
            rd_en_a = 1'b0;
            rd_en_b = 1'b0;
        end
    endtask

    initial begin
        vec_t vt [6];
        int   lat;
        int   lat_use;
        int   ovr0;
        logic pb;

        vt[0] = '{8'h96, 1'b1, 1'b0, 8'h96, 1'b1, 1'b0};
        vt[1] = '{8'h96, 1'b0, 1'b0, 8'h96, 1'b0, 1'b0};
        vt[2] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[3] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
        vt[4] = '{8'h5A, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b1};
        vt[5] = '{8'h81, 1'b1, 1'b1, 8'h81, 1'b1, 1'b1};

        repeat (3) @(negedge sysclk);
        chk("rst.valid", vld_a, 0);
        chk("rst.data", dat_a, 0);
        chk("rst.perr", pe_a, 0);
        chk("rst.ferr", fe_a, 0);
        chk("rst.full", full_a, 0);
        chk("rst.overrun", ovr_a, 0);
        chk("rst.valid_b", vld_b, 0);
        reset = 1'b1;
        drive(0, 1'b1, 2 * BIT);

        // Even-parity instance: table of good/bad parity and stop bits.
        for (int i = 0; i < 6; i++) begin
            pb = (^vt[i].d) ^ vt[i].bad_par;
            q_b.push_back('{vt[i].exp_d, vt[i].exp_p, vt[i].exp_f});
            send_char(1, vt[i].d, 1'b1, pb, ~vt[i].bad_stop);
            drive(1, 1'b1, BIT);
            pop_chk(1, $sformatf("par_vec%0d", i));
            chk($sformatf("par_vec%0d.empty", i), vld_b, 0);
        end

        // Single 8N1 character and its latency from the start edge.
        lat = 0;
        q_a.push_back('{8'hB9, 1'b0, 1'b0});
        fork
            send_char(0, 8'hB9, 1'b0, 1'b0, 1'b1);
            begin
                for (int i = 0; i < 4000; i++) begin
                    @(negedge sysclk);
                    lat++;
                    if (vld_a) break;
                end
            end
        join
        n_vec++;
        if (lat < 1520 || lat > 1528) begin
            n_err++;
            $display("FAIL latency: got %0d cycles, expected 1520..1528", lat);
        end
        lat_use = (lat >= 2 && lat < 3000) ? lat : 1524;
        pop_chk(0, "b9");
        chk("b9.empty", vld_a, 0);

        // Idle gap, then back-to-back characters.
        q_a.push_back('{8'h96, 1'b0, 1'b0});
        send_char(0, 8'h96, 1'b0, 1'b0, 1'b1);
        drive(0, 1'b1, 15 * BIT);
        q_a.push_back('{8'h1E, 1'b0, 1'b0});
        send_char(0, 8'h1E, 1'b0, 1'b0, 1'b1);
        drive(0, 1'b1, 2 * BIT);
        q_a.push_back('{8'hAA, 1'b0, 1'b0});
        send_char(0, 8'hAA, 1'b0, 1'b0, 1'b1);
        q_a.push_back('{8'h55, 1'b0, 1'b0});
        send_char(0, 8'h55, 1'b0, 1'b0, 1'b1);
        chk("b2b.full", full_a, 1);
        for (int i = 0; i < 4; i++) pop_chk(0, $sformatf("b2b%0d", i));
        chk("b2b.empty", vld_a, 0);

        // Line held low: one framing-error character, no repeats.
        q_a.push_back('{8'h00, 1'b0, 1'b1});
        drive(0, 1'b0, 12 * BIT);
        chk("brk.valid", vld_a, 1);
        pop_chk(0, "brk");
        drive(0, 1'b0, 2 * BIT);
        chk("brk.no_repeat_low", vld_a, 0);
        drive(0, 1'b1, 2 * BIT);
        chk("brk.no_repeat_high", vld_a, 0);

        // Fill to full, overrun on the fifth character.
        ovr0 = ovr_cnt;
        for (int d = 1; d <= 5; d++) begin
            if (d <= 4) q_a.push_back('{8'(d), 1'b0, 1'b0});
            send_char(0, 8'(d), 1'b0, 1'b0, 1'b1);
            drive(0, 1'b1, 20);
            if (d == 3) chk("fill.not_full_at_3", full_a, 0);
            if (d == 4) chk("fill.full_at_4", full_a, 1);
        end
        chk("fill.overrun_pulses", ovr_cnt - ovr0, 1);
        chk("fill.still_full", full_a, 1);
        for (int i = 0; i < 4; i++) pop_chk(0, $sformatf("fill%0d", i));
        chk("fill.empty", vld_a, 0);

        // Pop in the same cycle as a push into a full FIFO.
        ovr0 = ovr_cnt;
        for (int d = 8'h11; d <= 8'h14; d++) begin
            q_a.push_back('{8'(d), 1'b0, 1'b0});
            send_char(0, 8'(d), 1'b0, 1'b0, 1'b1);
            drive(0, 1'b1, 20);
        end
        chk("same.full_before", full_a, 1);
        q_a.push_back('{8'h15, 1'b0, 1'b0});
        fork
            send_char(0, 8'h15, 1'b0, 1'b0, 1'b1);
            begin
                repeat (lat_use - 1) @(negedge sysclk);
                chk("same.head", dat_a, q_a[0].d);
                void'(q_a.pop_front());
                rd_en_a = 1'b1;
                @(negedge sysclk);
                rd_en_a = 1'b0;
            end
        join
        drive(0, 1'b1, 20);
        chk("same.no_overrun", ovr_cnt - ovr0, 0);
        chk("same.full_after", full_a, 1);
        for (int i = 0; i < 4; i++) pop_chk(0, $sformatf("same%0d", i));

        // Short low glitch is rejected as a false start.
        drive(0, 1'b0, 40);
        drive(0, 1'b1, 3 * BIT);
        chk("glitch.no_entry", vld_a, 0);

        // Reset mid-character flushes FIFO and partial frame.
        q_a.push_back('{8'h42, 1'b0, 1'b0});
        send_char(0, 8'h42, 1'b0, 1'b0, 1'b1);
        drive(0, 1'b1, BIT);
        chk("rstmid.pre_valid", vld_a, 1);
        drive(0, 1'b0, BIT);
        for (int i = 0; i < 5; i++) drive(0, (i % 2 == 0) ? 1'b1 : 1'b0, BIT);
        reset = 1'b0;
        @(negedge sysclk);
        chk("rstmid.valid", vld_a, 0);
        chk("rstmid.data", dat_a, 0);
        q_a.delete();
        rxd_a = 1'b1;
        repeat (3) @(negedge sysclk);
        reset = 1'b1;
        drive(0, 1'b1, 12 * BIT);
        chk("rstmid.no_push", vld_a, 0);
        q_a.push_back('{8'h3C, 1'b0, 1'b0});
        send_char(0, 8'h3C, 1'b0, 1'b0, 1'b1);
        drive(0, 1'b1, BIT);
        pop_chk(0, "after_rst");
        chk("after_rst.empty", vld_a, 0);
        chk("sb.drained", q_a.size() + q_b.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
